// File: rtl/ccip_c0_rd_splitter.sv
// ccip_c0_rd_splitter
// Enforces the platform CCI-P capability set on the c0 (read) channel
// between the AFU and the FIU:
//   - multi-line reads of an unsupported length are split into single-line
//     reads, each tagged in mdata[15:13] with its line index;
//   - requests on an unsupported VC are remapped to VC_DEFAULT;
//   - responses tagged by the split logic get their cl_num and mdata restored.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   afu_req_*           AFU read request (valid/ready handshake)
//   fiu_almost_full     FIU c0 back-pressure
//   fiu_req_*           request toward the FIU (registered, 1-cycle latency)
//   fiu_rsp_*           read response from the FIU
//   afu_rsp_*           restored response toward the AFU (registered)
//   err_cl_len          sticky: an illegal cl_len (2) was accepted
//   err_mdata           sticky: an accepted request used mdata[15:13]
module ccip_c0_rd_splitter #(
   parameter logic [3:0] CL_LEN_SUPPORTED_MASK = 4'b0001,
   parameter logic [3:0] VC_SUPPORTED_MASK     = 4'b1111,
   parameter logic [1:0] VC_DEFAULT            = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        afu_req_valid,
   output logic        afu_req_ready,
   input  logic [41:0] afu_req_addr,
   input  logic [1:0]  afu_req_cl_len,
   input  logic [1:0]  afu_req_vc,
   input  logic [15:0] afu_req_mdata,
   input  logic        fiu_almost_full,
   output logic        fiu_req_valid,
   output logic [41:0] fiu_req_addr,
   output logic [1:0]  fiu_req_cl_len,
   output logic [1:0]  fiu_req_vc,
   output logic [15:0] fiu_req_mdata,
   input  logic        fiu_rsp_valid,
   input  logic [1:0]  fiu_rsp_cl_num,
   input  logic [15:0] fiu_rsp_mdata,
   output logic        afu_rsp_valid,
   output logic [1:0]  afu_rsp_cl_num,
   output logic [15:0] afu_rsp_mdata,
   output logic        err_cl_len,
   output logic        err_mdata
);

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t      state;
   logic [1:0]  line_idx;     // index of the next split line to emit
   logic [1:0]  line_last;    // index of the final split line (1 or 3)
   logic [41:0] lat_addr;
   logic [1:0]  lat_vc;       // already remapped at accept time
   logic [12:0] lat_mdata;
   logic        accept;

   function automatic logic [1:0] map_vc(input logic [1:0] vc);
      return VC_SUPPORTED_MASK[vc] ? vc : VC_DEFAULT;
   endfunction

   // Ready is forced low while reset is held so nothing is accepted then.
   assign afu_req_ready = !reset && (state == IDLE) && !fiu_almost_full;
   assign accept        = afu_req_valid && afu_req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         line_idx       <= 2'd0;
         line_last      <= 2'd0;
         lat_addr       <= '0;
         lat_vc         <= 2'd0;
         lat_mdata      <= '0;
         fiu_req_valid  <= 1'b0;
         fiu_req_addr   <= '0;
         fiu_req_cl_len <= 2'd0;
         fiu_req_vc     <= 2'd0;
         fiu_req_mdata  <= '0;
         err_cl_len     <= 1'b0;
         err_mdata      <= 1'b0;
      end else begin
         fiu_req_valid <= 1'b0;
         if (accept && (afu_req_mdata[15:13] != 3'b000)) begin
            err_mdata <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  // cl_len 2 is illegal: swallow it regardless of the mask.
                  if (afu_req_cl_len == 2'd2) begin
                     err_cl_len <= 1'b1;
                  end else if (CL_LEN_SUPPORTED_MASK[afu_req_cl_len]) begin
                     fiu_req_valid  <= 1'b1;
                     fiu_req_addr   <= afu_req_addr;
                     fiu_req_cl_len <= afu_req_cl_len;
                     fiu_req_vc     <= map_vc(afu_req_vc);
                     fiu_req_mdata  <= afu_req_mdata;
                  end else begin
                     lat_addr  <= afu_req_addr;
                     lat_vc    <= map_vc(afu_req_vc);
                     lat_mdata <= afu_req_mdata[12:0];
                     line_idx  <= 2'd0;
                     line_last <= (afu_req_cl_len == 2'd3) ? 2'd3 : 2'd1;
                     state     <= SPLIT;
                  end
               end
            end
            SPLIT: begin
               if (!fiu_almost_full) begin
                  // Low address bits of a multi-line read are aligned, so
                  // OR-ing the index in selects the individual line.
                  fiu_req_valid  <= 1'b1;
                  fiu_req_addr   <= lat_addr | {40'd0, line_idx};
                  fiu_req_cl_len <= 2'd0;
                  fiu_req_vc     <= lat_vc;
                  fiu_req_mdata  <= {1'b1, line_idx, lat_mdata};
                  if (line_idx == line_last) begin
                     state <= IDLE;
                  end else begin
                     line_idx <= line_idx + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response restore: bit 15 marks a response to a split line; its line
   // index rides in bits [14:13] and the reserved bits go back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         afu_rsp_valid  <= 1'b0;
         afu_rsp_cl_num <= 2'd0;
         afu_rsp_mdata  <= '0;
      end else begin
         afu_rsp_valid <= fiu_rsp_valid;
         if (fiu_rsp_mdata[15]) begin
            afu_rsp_cl_num <= fiu_rsp_mdata[14:13];
            afu_rsp_mdata  <= {3'b000, fiu_rsp_mdata[12:0]};
         end else begin
            afu_rsp_cl_num <= fiu_rsp_cl_num;
            afu_rsp_mdata  <= fiu_rsp_mdata;
         end
      end
   end

endmodule

// File: tb/tb_ccip_c0_rd_splitter.sv
// Bench for ccip_c0_rd_splitter. Two instances with different capability
// masks share one stimulus stream; each has its own reference model that
// keeps the FIU packets still owed to that instance in a small FIFO.
module tb_ccip_c0_rd_splitter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [41:0] req_addr;
   logic [1:0]  req_cl;
   logic [1:0]  req_vc;
   logic [15:0] req_md;
   logic        af;
   logic        rsp_valid;
   logic [1:0]  rsp_cl;
   logic [15:0] rsp_md;

   logic        ready [2];
   logic        fv    [2];
   logic [41:0] fa    [2];
   logic [1:0]  fcl   [2];
   logic [1:0]  fvc   [2];
   logic [15:0] fmd   [2];
   logic        rv    [2];
   logic [1:0]  rcn   [2];
   logic [15:0] rmd   [2];
   logic        ecl   [2];
   logic        emd   [2];

   // Model state: owed packets {addr, cl_len, vc, mdata}, sticky errors.
   logic [61:0] q [2][8];
   int          hd  [2];
   int          cnt [2];
   bit          e_cl [2];
   bit          e_md [2];
   int          n_chk;
   int          n_pass;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ccip_c0_rd_splitter #(
         .CL_LEN_SUPPORTED_MASK(g == 0 ? 4'b1011 : 4'b0001),
         .VC_SUPPORTED_MASK    (g == 0 ? 4'b1111 : 4'b0011),
         .VC_DEFAULT           (g == 0 ? 2'd0 : 2'd1)
      ) dut (
         .clk            (clk),
         .reset          (rst),
         .afu_req_valid  (req_valid),
         .afu_req_ready  (ready[g]),
         .afu_req_addr   (req_addr),
         .afu_req_cl_len (req_cl),
         .afu_req_vc     (req_vc),
         .afu_req_mdata  (req_md),
         .fiu_almost_full(af),
         .fiu_req_valid  (fv[g]),
         .fiu_req_addr   (fa[g]),
         .fiu_req_cl_len (fcl[g]),
         .fiu_req_vc     (fvc[g]),
         .fiu_req_mdata  (fmd[g]),
         .fiu_rsp_valid  (rsp_valid),
         .fiu_rsp_cl_num (rsp_cl),
         .fiu_rsp_mdata  (rsp_md),
         .afu_rsp_valid  (rv[g]),
         .afu_rsp_cl_num (rcn[g]),
         .afu_rsp_mdata  (rmd[g]),
         .err_cl_len     (ecl[g]),
         .err_mdata      (emd[g])
      );
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [3:0] len_mask(input int d);
      return (d == 0) ? 4'b1011 : 4'b0001;
   endfunction

   function automatic logic [1:0] vmap(input int d, input logic [1:0] vc);
      logic [3:0] m;
      m = (d == 0) ? 4'b1111 : 4'b0011;
      if (m[vc]) return vc;
      return (d == 0) ? 2'd0 : 2'd1;
   endfunction

   task automatic push(input int d, input logic [61:0] p);
      q[d][(hd[d] + cnt[d]) % 8] = p;
      cnt[d]++;
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         hd[d]   = 0;
         cnt[d]  = 0;
         e_cl[d] = 1'b0;
         e_md[d] = 1'b0;
      end
   endtask

   // One clock: check ready, take the edge, then check everything the edge
   // should have produced. Inputs stay put until the caller changes them.
   task automatic step();
      bit         acc [2];
      bit         er;
      bit         due;
      logic [3:0] m;
      int         nlines;
      logic [61:0] p;
      #1;
      for (int d = 0; d < 2; d++) begin
         er = !af && (cnt[d] == 0);
         chk($sformatf("ready%0d", d), 64'(ready[d]), 64'(er));
         acc[d] = req_valid && er;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         due = (cnt[d] > 0) && !af;
         if (acc[d]) begin
            m = len_mask(d);
            if (req_md[15:13] != 3'b000) e_md[d] = 1'b1;
            if (req_cl == 2'd2) begin
               e_cl[d] = 1'b1;
            end else if (m[req_cl]) begin
               push(d, {req_addr, req_cl, vmap(d, req_vc), req_md});
               due = 1'b1;
            end else begin
               nlines = (req_cl == 2'd3) ? 4 : 2;
               for (int k = 0; k < nlines; k++)
                  push(d, {req_addr | 42'(k), 2'd0, vmap(d, req_vc), 1'b1, 2'(k), req_md[12:0]});
            end
         end
         chk($sformatf("fiu_valid%0d", d), 64'(fv[d]), 64'(due));
         if (due) begin
            p = q[d][hd[d]];
            chk($sformatf("fiu_pkt%0d", d), 64'({fa[d], fcl[d], fvc[d], fmd[d]}), 64'(p));
            hd[d] = (hd[d] + 1) % 8;
            cnt[d]--;
         end
         chk($sformatf("errs%0d", d), 64'({ecl[d], emd[d]}), 64'({e_cl[d], e_md[d]}));
         chk($sformatf("rsp_valid%0d", d), 64'(rv[d]), 64'(rsp_valid));
         if (rsp_valid) begin
            if (rsp_md[15])
               chk($sformatf("rsp_split%0d", d), 64'({rcn[d], rmd[d]}),
                   64'({rsp_md[14:13], 3'b000, rsp_md[12:0]}));
            else
               chk($sformatf("rsp_pass%0d", d), 64'({rcn[d], rmd[d]}), 64'({rsp_cl, rsp_md}));
         end
      end
   endtask

   task automatic reset_outputs_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_req%0d", tag, d),
             64'({ready[d], fv[d], fa[d], fcl[d], fvc[d], fmd[d]}), 64'd0);
         chk($sformatf("%s_rsp%0d", tag, d),
             64'({rv[d], rcn[d], rmd[d], ecl[d], emd[d]}), 64'd0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      reset_outputs_zero("rst_now");
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset_outputs_zero("rst_hold");
      rst = 1'b0;
   endtask

   task automatic send(input logic [41:0] a, input logic [1:0] cl,
                       input logic [1:0] vc, input logic [15:0] md);
      req_valid = 1'b1;
      req_addr  = a;
      req_cl    = cl;
      req_vc    = vc;
      req_md    = md;
      step();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_cl    = 2'd0;
      req_vc    = 2'd0;
      req_md    = '0;
      af        = 1'b0;
      rsp_valid = 1'b0;
      rsp_cl    = 2'd0;
      rsp_md    = '0;
      model_clear();
      do_reset();
      idle(2);

      // Supported 4-line read on instance 0, split on instance 1.
      send(42'h100, 2'd3, 2'd1, 16'h0005);
      idle(6);
      send(42'h200, 2'd3, 2'd0, 16'h0012);
      idle(6);

      // Back-pressure after the second split line.
      send(42'h200, 2'd3, 2'd0, 16'h0012);
      step();
      step();
      af = 1'b1;
      repeat (3) step();
      af = 1'b0;
      idle(4);

      // Response restore, tagged and untagged.
      rsp_valid = 1'b1;
      rsp_md    = 16'hC012;
      rsp_cl    = 2'd0;
      step();
      rsp_md    = 16'h0034;
      rsp_cl    = 2'd3;
      step();
      rsp_valid = 1'b0;
      idle(1);

      // VC remap, illegal length, reserved mdata bits.
      send(42'h300, 2'd0, 2'd2, 16'h0000);
      idle(1);
      send(42'h400, 2'd2, 2'd0, 16'h0000);
      idle(1);
      send(42'h500, 2'd0, 2'd0, 16'h2000);
      idle(2);

      // Reset in the middle of a split, then a single-line read.
      send(42'h600, 2'd3, 2'd0, 16'h0007);
      step();
      step();
      do_reset();
      idle(4);
      send(42'h700, 2'd0, 2'd3, 16'h0001);
      idle(2);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = {10'($urandom), 32'($urandom)};
         req_addr[1:0] = 2'd0;
         req_cl    = 2'($urandom);
         req_vc    = 2'($urandom);
         req_md    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {3'b000, 13'($urandom)};
         af        = ($urandom_range(0, 3) == 0);
         rsp_valid = 1'($urandom_range(0, 1));
         rsp_cl    = 2'($urandom);
         rsp_md    = 16'($urandom);
         step();
      end
      req_valid = 1'b0;
      af        = 1'b0;
      rsp_valid = 1'b0;
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ccip_c0_rd_splitter.md
Name: ccip_c0_rd_splitter

Overview:
Sits between the AFU and the FIU on the CCI-P c0 read path, and enforces the platform capability set on outgoing reads.
- Multi-line reads whose length the platform does not support are split into single-line reads.
- Requests on an unsupported VC are remapped to the default VC.
- Returning read responses are restored to the cl_num the AFU expects.
- This is the enforcing end of the platform CCI-P capability advertisement: AFUs that ignore the advertised capabilities still produce legal traffic.

Parameters:
CL_LEN_SUPPORTED_MASK, 4'b0001, bit i=1 means cl_len encoding i is supported by the FIU (bit 0 must be 1).
VC_SUPPORTED_MASK, 4'b1111, bit i=1 means VC encoding i is supported.
VC_DEFAULT, 2'd0, VC substituted for unsupported VCs.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
afu_req_valid  in  1  AFU read request valid
afu_req_ready  out  1  splitter accepts request this cycle
afu_req_addr  in  42  line address
afu_req_cl_len  in  2  0=1 line, 1=2 lines, 3=4 lines, 2=illegal
afu_req_vc  in  2  requested VC
afu_req_mdata  in  16  AFU metadata; bits [15:13] reserved, must be 0
fiu_almost_full  in  1  FIU c0 almost-full
fiu_req_valid  out  1  request to FIU
fiu_req_addr  out  42  line address
fiu_req_cl_len  out  2  length
fiu_req_vc  out  2  VC
fiu_req_mdata  out  16  metadata
fiu_rsp_valid  in  1  read response valid
fiu_rsp_cl_num  in  2  FIU line number
fiu_rsp_mdata  in  16  FIU response metadata
afu_rsp_valid  out  1  response to AFU
afu_rsp_cl_num  out  2  restored line number
afu_rsp_mdata  out  16  restored metadata
err_cl_len  out  1  sticky: illegal cl_len seen
err_mdata  out  1  sticky: AFU mdata[15:13] nonzero

Behaviour:
- Reset: all outputs 0 except afu_req_ready, which is also 0 during reset. FSM enters IDLE, split counter is 0, sticky errors are cleared. Reset asserted mid-split abandons the split: remaining lines are not issued.
- Handshake: a request is accepted when afu_req_valid && afu_req_ready. In IDLE, afu_req_ready = !fiu_almost_full.
- VC mapping: out vc = VC_SUPPORTED_MASK[vc] ? vc : VC_DEFAULT.
- Supported length (CL_LEN_SUPPORTED_MASK[cl_len]=1, cl_len≠2): pass-through, registered, 1-cycle latency. fiu_req_valid is high for 1 cycle with addr, cl_len and mdata unchanged; VC is mapped. FSM stays IDLE.
- Unsupported length, cl_len 1 or 3 (N=2 or 4):
  - On accept, latch the request and go to SPLIT. afu_req_ready=0 while in SPLIT.
  - Each cycle in SPLIT with !fiu_almost_full, emit line k:
    - addr = latched addr | k; low bits are assumed aligned and are overwritten, not added.
    - cl_len = 0, mapped VC.
    - mdata = {1'b1, k[1:0], latched mdata[12:0]}.
  - k starts at 0 and increments per emitted line. fiu_almost_full high stalls emission; k holds.
  - After line N-1 is emitted, return to IDLE. afu_req_ready may rise the following cycle, so there is no back-to-back accept on the last split cycle.
- cl_len==2: the request is accepted and dropped (no FIU output), and err_cl_len is set. This has priority over split.
- Any accepted request with mdata[15:13]≠0 sets err_mdata. The request is still processed; on split, bits [15:13] are overwritten.
- Response path: registered, 1-cycle latency, independent of the request FSM, and never stalled.
  - If fiu_rsp_mdata[15]=1: afu_rsp_cl_num = mdata[14:13], and afu_rsp_mdata = {3'b000, mdata[12:0]}.
  - Otherwise cl_num and mdata pass unchanged.
- Simultaneous request emission and response in the same cycle are fully independent.

Test Plan:
1. CL_LEN_SUPPORTED_MASK=4'b1011, req addr=0x100, cl_len=3, vc=1, mdata=0x0005 -> one FIU packet the next cycle with cl_len=3, addr=0x100, mdata=0x0005; afu_req_ready stays high.
2. Mask=4'b0001, req addr=0x200, cl_len=3, mdata=0x0012 -> 4 FIU packets on consecutive cycles: addr 0x200..0x203, cl_len=0, mdata 0x8012, 0xA012, 0xC012, 0xE012; afu_req_ready=0 for 4 cycles.
3. Same as test 2 with fiu_almost_full high for 3 cycles after the second packet -> exactly 4 packets total, no duplicates or gaps, third packet emitted the cycle after almost_full drops.
4. Response mdata=0xC012, cl_num=0 -> afu_rsp_cl_num=2 and afu_rsp_mdata=0x0012 one cycle later; response mdata=0x0034, cl_num=3 -> passes unchanged.
5. VC_SUPPORTED_MASK=4'b0011, VC_DEFAULT=1, req vc=2 -> fiu_req_vc=1. Req cl_len=2 -> no FIU packet and err_cl_len=1 (sticky). Req mdata=0x2000 -> err_mdata=1.
6. Assert reset after the second of 4 split packets -> no further packets; after release the FSM is IDLE and a new single-line request passes with 1-cycle latency.
